// File: rtl/uni_bitstream_decoder_pkg.sv
// Shared types and helpers for the unary-to-binary bitstream decoder.
// The count width depends on a module parameter, so the typedef is supplied as a macro.
`ifndef UNI_CNT_T
`define UNI_CNT_T(W) logic [(W):0]
`endif

package uni_pkg;

    localparam int INWD_DEF = 8;

    // Number of samples in one window for a given log2 window length.
    function automatic int win_len(input int inwd);
        return 1 << inwd;
    endfunction

endpackage

// File: rtl/uni_bitstream_decoder_win_counter.sv
// Window sample counter and ones accumulator; flags the cycle that completes a window
// and presents the (optionally saturated) count of that window combinationally.
module uni_win_counter
    import uni_pkg::*;
#(
    parameter int INWD    = INWD_DEF,
    parameter bit ONE_SAT = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_en_i,
    input  logic            in_bit_i,
    input  logic            sync_clr_i,
    output logic            done_o,
    output logic [INWD:0]   res_o
);

    typedef `UNI_CNT_T(INWD) uni_cnt_t;
    typedef logic [INWD-1:0] idx_t;

    localparam uni_cnt_t WIN    = uni_cnt_t'(win_len(INWD));
    localparam uni_cnt_t WIN_M1 = uni_cnt_t'(win_len(INWD) - 1);

    idx_t     cnt_q, cnt_d;
    uni_cnt_t acc_q, acc_d;
    uni_cnt_t sum;

    assign sum = acc_q + uni_cnt_t'(in_bit_i);

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        done_o = 1'b0;
        // A restart outranks completion: the sample taken with it opens the new window.
        if (sync_clr_i) begin
            cnt_d = in_en_i ? idx_t'(1) : '0;
            acc_d = in_en_i ? uni_cnt_t'(in_bit_i) : '0;
        end else if (in_en_i) begin
            if (cnt_q == '1) begin
                done_o = 1'b1;
                cnt_d  = '0;
                acc_d  = '0;
            end else begin
                cnt_d = cnt_q + idx_t'(1);
                acc_d = sum;
            end
        end
    end

    generate
        if (ONE_SAT) begin : g_sat
            assign res_o = (sum == WIN) ? WIN_M1 : sum;
        end else begin : g_exact
            assign res_o = sum;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uni_bitstream_decoder.sv
// Unary-to-binary decoder: counts ones per 2^INWD accepted samples and offers each count
// through a one-entry valid/ready output register with a sticky drop flag.
module uni_bitstream_decoder
    import uni_pkg::*;
#(
    parameter int INWD    = INWD_DEF,
    parameter bit ONE_SAT = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_en_i,
    input  logic            in_bit_i,
    input  logic            sync_clr_i,
    output logic [INWD:0]   out_data_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            ovf_o,
    input  logic            ovf_clr_i
);

    typedef `UNI_CNT_T(INWD) uni_cnt_t;

    logic     win_done;
    uni_cnt_t win_res;

    uni_cnt_t data_q, data_d;
    logic     valid_q, valid_d;
    logic     ovf_q, ovf_d;
    logic     reg_free;
    logic     drop;

    uni_win_counter #(
        .INWD    (INWD),
        .ONE_SAT (ONE_SAT)
    ) u_win_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_en_i    (in_en_i),
        .in_bit_i   (in_bit_i),
        .sync_clr_i (sync_clr_i),
        .done_o     (win_done),
        .res_o      (win_res)
    );

    // A result being consumed this cycle frees the slot for a new one without a bubble.
    assign reg_free = !valid_q || out_ready_i;
    assign drop     = win_done && !reg_free;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (win_done && reg_free) begin
            data_d  = win_res;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign ovf_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign ovf_o       = ovf_q;

endmodule
